// File: rtl/i2c_target_regs_if.sv
// I2C pin levels plus the fabric register port of i2c_target_regs; slave modport faces the target.
interface i2c_target_regs_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       busy;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       usr_we;
  logic [3:0] usr_addr;
  logic [7:0] usr_wdata;
  logic [7:0] usr_rdata;

  modport slave (
    input  scl_in, sda_in, usr_we, usr_addr, usr_wdata,
    output sda_oe, busy, wr_strobe, wr_addr, wr_data, usr_rdata
  );

  modport master (
    output scl_in, sda_in, usr_we, usr_addr, usr_wdata,
    input  sda_oe, busy, wr_strobe, wr_addr, wr_data, usr_rdata
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a 16x8 register bank; I2C_TGT_GLITCH_FILTER_EN adds a FILTER_CYC-cycle filter on SCL/SDA.
// Pins seen 2 cycles after an edge (+FILTER_CYC filtered), wr_strobe 1 cycle after the 8th-bit rise; no backpressure.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR   = 7'h3A,
  parameter int unsigned FILTER_CYC = 3
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  i2c_target_regs_if.slave bus
);

  if (FILTER_CYC < 1 || FILTER_CYC > 15) begin : g_filter_range
    $error("FILTER_CYC must be within 1..15");
  end

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK, ST_WAIT_P
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_s, sda_s, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] byte_in;
  logic [3:0] ptr, ptr_inc;
  logic       rw;
  logic       last_bit, addr_hit;
  logic       sda_drive, i2c_we;
  logic       sda_oe_q, busy_q, wr_strobe_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] bank [16];

  // Bus idles high, so the synchronizers come out of reset at 1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILTER_CYC - 1);
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_filt, sda_filt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
    end else begin
      if (scl_sync[1] == scl_filt)  scl_cnt <= '0;
      else if (scl_cnt == FILT_LAST) begin
        scl_filt <= scl_sync[1];
        scl_cnt  <= '0;
      end else                      scl_cnt <= scl_cnt + 4'd1;
      if (sda_sync[1] == sda_filt)  sda_cnt <= '0;
      else if (sda_cnt == FILT_LAST) begin
        sda_filt <= sda_sync[1];
        sda_cnt  <= '0;
      end else                      sda_cnt <= sda_cnt + 4'd1;
    end
  end

  assign scl_s = scl_filt;
  assign sda_s = sda_filt;
`else
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign byte_in  = {shift[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);
  assign addr_hit = (byte_in[7:1] == DEV_ADDR);
  assign ptr_inc  = ptr + 4'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = ST_IDLE;
    else if (start_det) state_nxt = ST_ADDR;
    else if (scl_rise) begin
      case (state)
        ST_ADDR:     if (last_bit) state_nxt = addr_hit ? ST_ADDR_ACK : ST_WAIT_P;
        ST_ADDR_ACK: state_nxt = rw ? ST_RD : ST_PTR;
        ST_PTR:      if (last_bit) state_nxt = ST_PTR_ACK;
        ST_PTR_ACK:  state_nxt = ST_WR;
        ST_WR:       if (last_bit) state_nxt = ST_WR_ACK;
        ST_WR_ACK:   state_nxt = ST_WR;
        ST_RD:       if (last_bit) state_nxt = ST_RD_ACK;
        ST_RD_ACK:   state_nxt = sda_s ? ST_WAIT_P : ST_RD;
        default:     ;
      endcase
    end
  end

  // Level the target wants on SDA for the bit that starts at the next SCL fall.
  always_comb begin
    sda_drive = 1'b0;
    case (state)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: sda_drive = 1'b1;
      ST_RD:                              sda_drive = ~shift[7];
      default:                            ;
    endcase
    i2c_we = (state == ST_WR) && scl_rise && last_bit;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt     <= '0;
      shift       <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_strobe_q <= i2c_we;
      if (i2c_we) begin
        wr_addr_q <= ptr;
        wr_data_q <= byte_in;
      end
      if (stop_det)      sda_oe_q <= 1'b0;
      else if (scl_fall) sda_oe_q <= sda_drive;
      if (stop_det)                                        busy_q <= 1'b0;
      else if (scl_rise && state == ST_ADDR && last_bit)   busy_q <= addr_hit;
      if (start_det) bit_cnt <= '0;
      else if (scl_rise) begin
        case (state)
          ST_ADDR: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) rw <= sda_s;
          end
          ST_PTR: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) ptr <= byte_in[3:0];
          end
          ST_WR: begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) ptr <= ptr_inc;
          end
          ST_ADDR_ACK: if (rw) shift <= bank[ptr];
          ST_RD: begin
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_RD_ACK: if (!sda_s) begin
            ptr   <= ptr_inc;
            shift <= bank[ptr_inc];
          end
          default: ;
        endcase
      end
    end
  end

  // Same-index collision: the I2C byte wins and the fabric write is dropped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (i2c_we && ptr == 4'(i))                      bank[i] <= byte_in;
        else if (bus.usr_we && bus.usr_addr == 4'(i))    bank[i] <= bus.usr_wdata;
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.usr_rdata = bank[bus.usr_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C initiator, register-bank model and strobe scoreboard.
module tb_i2c_target_regs;
  localparam int Q = 8;
`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int         FILT        = 3;
  localparam logic [7:0] GLITCH_BYTE = 8'h5A;
  localparam logic       GLITCH_ACK  = 1'b0;
`else
  localparam int         FILT        = 0;
  localparam logic [7:0] GLITCH_BYTE = 8'h2D;
  localparam logic       GLITCH_ACK  = 1'b1;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic m_sda = 1'b1;

  i2c_target_regs_if bif();
  assign bif.sda_in = m_sda & ~bif.sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h3A), .FILTER_CYC(3)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bif)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  m_bank [16];
  logic [3:0]  m_ptr = '0;
  logic [11:0] exp_q[$];
  logic [7:0]  wq[$];
  logic [12:0] cq[$];
  logic        quiet_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Every strobe must match the next scoreboard entry; quiet windows forbid any target activity.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (bif.wr_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got addr %0h data %0h, want no strobe", bif.wr_addr, bif.wr_data);
        end else begin
          chk("strobe", {20'd0, bif.wr_addr, bif.wr_data}, {20'd0, exp_q.pop_front()});
        end
      end
      if (quiet_chk) chk("quiet_bus", {29'd0, bif.sda_oe, bif.busy, bif.wr_strobe}, 32'd0);
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog: got timeout, want completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    if (bif.scl_in == 1'b0) begin
      m_sda = 1'b1; cyc(Q);
      bif.scl_in = 1'b1; cyc(Q);
    end
    m_sda = 1'b0; cyc(Q);
    bif.scl_in = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(Q);
    bif.scl_in = 1'b1; cyc(Q);
    m_sda = 1'b1; cyc(2 * Q);
  endtask

  // One SCL clock; optional 2-cycle SCL glitch in the low phase, optional fabric write timed to the bank write.
  task automatic bit_xfer(input logic b, input logic glitch, input logic coll, output logic rb);
    m_sda = b;
    if (glitch) begin
      cyc(2); bif.scl_in = 1'b1;
      cyc(2); bif.scl_in = 1'b0;
      cyc(Q - 4);
    end else begin
      cyc(Q);
    end
    bif.scl_in = 1'b1;
    for (int c = 1; c <= Q; c++) begin
      cyc(1);
      if (coll && c == 2 + FILT) bif.usr_we = 1'b1;
      if (coll && c == 3 + FILT) bif.usr_we = 1'b0;
    end
    rb = bif.sda_in;
    cyc(Q);
    bif.scl_in = 1'b0;
    cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, input int coll_bit, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], glitch_bit == i, coll_bit == i, rb);
    bit_xfer(1'b1, 1'b0, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, 1'b0, rb);
      d[i] = rb;
    end
    bit_xfer(nack, 1'b0, 1'b0, rb);
  endtask

  task automatic usr_write(input logic [3:0] a, input logic [7:0] d);
    bif.usr_addr = a; bif.usr_wdata = d; bif.usr_we = 1'b1;
    cyc(1);
    bif.usr_we = 1'b0;
    m_bank[a] = d;
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [7:0] want);
    bif.usr_addr = a;
    cyc(1);
    chk(name, {24'd0, bif.usr_rdata}, {24'd0, want});
  endtask

  // Write transaction of the bytes in wq; cq flags bytes that carry a simultaneous fabric write.
  task automatic i2c_write(input logic [7:0] ptr_byte);
    logic ack;
    i2c_start();
    send_byte(8'h74, -1, -1, ack);
    chk("addr_ack", {31'd0, ack}, 32'd0);
    chk("busy_addressed", {31'd0, bif.busy}, 32'd1);
    send_byte(ptr_byte, -1, -1, ack);
    chk("ptr_ack", {31'd0, ack}, 32'd0);
    m_ptr = ptr_byte[3:0];
    foreach (wq[k]) begin
      logic coll;
      coll = (k < cq.size()) && cq[k][12];
      if (coll) begin
        bif.usr_addr  = cq[k][11:8];
        bif.usr_wdata = cq[k][7:0];
        if (cq[k][11:8] != m_ptr) m_bank[cq[k][11:8]] = cq[k][7:0];
      end
      exp_q.push_back({m_ptr, wq[k]});
      m_bank[m_ptr] = wq[k];
      m_ptr = m_ptr + 4'd1;
      send_byte(wq[k], -1, coll ? 0 : -1, ack);
      chk("data_ack", {31'd0, ack}, 32'd0);
    end
    i2c_stop();
    chk("busy_after_stop", {31'd0, bif.busy}, 32'd0);
    wq.delete();
    cq.delete();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
    bif.scl_in = 1'b1; bif.usr_we = 1'b0; bif.usr_addr = '0; bif.usr_wdata = '0;
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(2);
    chk("reset_outputs", {17'd0, bif.sda_oe, bif.busy, bif.wr_strobe, bif.wr_addr, bif.wr_data}, 32'd0);
    peek("reset_bank0", 4'd0, 8'h00);
    peek("reset_bank15", 4'd15, 8'h00);

    // Write burst to 5 and 6.
    wq = '{8'h11, 8'h22};
    i2c_write(8'h05);
    chk("wr_last", {20'd0, bif.wr_addr, bif.wr_data}, 32'h622);
    peek("bank5_lit", 4'd5, 8'h11);
    peek("bank6_lit", 4'd6, 8'h22);

    // Pointer write then read with wrap 15 -> 0.
    usr_write(4'd15, 8'hA5);
    usr_write(4'd0, 8'h3C);
    i2c_start();
    send_byte(8'h74, -1, -1, ack); chk("rd_addr_w_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h0F, -1, -1, ack); chk("rd_ptr_ack", {31'd0, ack}, 32'd0);
    m_ptr = 4'hF;
    i2c_start();
    send_byte(8'h75, -1, -1, ack); chk("rd_addr_r_ack", {31'd0, ack}, 32'd0);
    recv_byte(1'b0, d);
    chk("rd_byte0", {24'd0, d}, {24'd0, m_bank[m_ptr]});
    chk("rd_byte0_lit", {24'd0, d}, 32'hA5);
    m_ptr = m_ptr + 4'd1;
    recv_byte(1'b1, d);
    chk("rd_byte1", {24'd0, d}, {24'd0, m_bank[m_ptr]});
    chk("rd_byte1_lit", {24'd0, d}, 32'h3C);
    chk("release_after_nack", {31'd0, bif.sda_oe}, 32'd0);
    i2c_stop();

    // Address mismatch: target must stay silent throughout.
    quiet_chk = 1'b1;
    i2c_start();
    send_byte(8'h40, -1, -1, ack); chk("mismatch_nack0", {31'd0, ack}, 32'd1);
    send_byte(8'h01, -1, -1, ack); chk("mismatch_nack1", {31'd0, ack}, 32'd1);
    send_byte(8'hFF, -1, -1, ack); chk("mismatch_nack2", {31'd0, ack}, 32'd1);
    i2c_stop();
    quiet_chk = 1'b0;
    peek("mismatch_bank1", 4'd1, m_bank[1]);

    // Collisions: same index (I2C wins) then different indices (both commit).
    wq = '{8'h99, 8'h66};
    cq = '{{1'b1, 4'd3, 8'h44}, {1'b1, 4'd7, 8'h55}};
    i2c_write(8'h03);
    peek("coll_same_lit", 4'd3, 8'h99);
    peek("coll_diff_i2c_lit", 4'd4, 8'h66);
    peek("coll_diff_usr_lit", 4'd7, 8'h55);

    // Reset while the target drives a read bit.
    usr_write(4'd8, 8'h12);
    i2c_start();
    send_byte(8'h74, -1, -1, ack); chk("rst_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h08, -1, -1, ack); chk("rst_ptr_ack", {31'd0, ack}, 32'd0);
    i2c_start();
    send_byte(8'h75, -1, -1, ack); chk("rst_addr_r_ack", {31'd0, ack}, 32'd0);
    chk("rd_drive_low", {31'd0, bif.sda_oe}, 32'd1);
    #1 sys_rst_n = 1'b0;
    #1 chk("rst_sda_oe", {31'd0, bif.sda_oe}, 32'd0);
    chk("rst_outputs_mid", {17'd0, bif.sda_oe, bif.busy, bif.wr_strobe, bif.wr_addr, bif.wr_data}, 32'd0);
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
    m_ptr = '0;
    cyc(2);
    sys_rst_n = 1'b1;
    peek("rst_bank8", 4'd8, 8'h00);
    cyc(2);
    i2c_stop();
    wq = '{8'h77};
    i2c_write(8'h02);
    peek("post_rst_bank2_lit", 4'd2, 8'h77);

    // SCL glitch in the first data bit.
    i2c_start();
    send_byte(8'h74, -1, -1, ack); chk("gl_addr_ack", {31'd0, ack}, 32'd0);
    send_byte(8'h09, -1, -1, ack); chk("gl_ptr_ack", {31'd0, ack}, 32'd0);
    exp_q.push_back({4'h9, GLITCH_BYTE});
    m_bank[9] = GLITCH_BYTE;
    send_byte(8'h5A, 7, -1, ack);
    chk("glitch_ack", {31'd0, ack}, {31'd0, GLITCH_ACK});
    i2c_stop();
    peek("glitch_byte", 4'd9, GLITCH_BYTE);

    for (int i = 0; i < 16; i++) peek("bank_dump", 4'(i), m_bank[i]);
    chk("strobes_pending", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with a 16 × 8-bit register bank. It is the far end of the I2C initiator driving `scl`/`sda` on the board. An external initiator (MCU or the FPGA's own master in loopback) writes a register pointer followed by data bytes, or reads bytes back from the pointer. Fabric logic sees every I2C write as a one-cycle strobe and can preload registers for the initiator to read.

## Interface
Parameters:
- `DEV_ADDR`, 7'h3A: 7-bit target address matched after START.
- `FILTER_CYC`, 3: glitch-filter stability length in `sys_clk` cycles. Used only with `I2C_TGT_GLITCH_FILTER_EN`; legal range 1–15.

Ports:
- `sys_clk` in 1: system clock, 50 MHz; must be ≥ 20 × SCL rate.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `scl_in` in 1: raw SCL pin level.
- `sda_in` in 1: raw SDA pin level.
- `sda_oe` out 1: 1 = pull SDA low; the top-level tri-state drives 0 or Z.
- `busy` out 1: 1 from an addressed START (address match) until STOP or address mismatch.
- `wr_strobe` out 1: one-cycle pulse per data byte written by the initiator.
- `wr_addr` out 4: register index of the last written byte.
- `wr_data` out 8: value of the last written byte.
- `usr_we` in 1: fabric write enable into the bank.
- `usr_addr` in 4: fabric write/read index.
- `usr_wdata` in 8: fabric write data.
- `usr_rdata` out 8: combinational `bank[usr_addr]`.

## Operation
- **Input conditioning.** `scl_in` and `sda_in` each pass through a 2-FF synchronizer.
  - Edge and condition detection compare the synchronized value with its 1-cycle delay.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bits are sampled on the SCL rising edge.
  - `sda_oe` changes only one cycle after a detected SCL falling edge.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_P.
- **Global transitions:**
  - START in any state → ADDR, with the bit counter cleared. A repeated START keeps the pointer.
  - STOP in any state → IDLE, with `sda_oe` = 0 and `busy` = 0.
- **ADDR:** shift in 8 bits, MSB first.
  - On match of bits [7:1] with `DEV_ADDR` → ADDR_ACK and `busy` = 1.
  - On mismatch → WAIT_P with SDA released.
- **ADDR_ACK:** drive ACK for one SCL clock.
  - R/W = 0 → PTR.
  - R/W = 1 → load `shift` = `bank[ptr]` → RD.
- **PTR:** receive 8 bits; `ptr` = bits [3:0], bits [7:4] ignored → PTR_ACK (ACK) → WR.
- **WR:** receive 8 bits → WR_ACK (ACK). At the SCL rise that samples the 8th bit:
  - `bank[ptr]` ← byte.
  - `wr_strobe` = 1 for one cycle; `wr_addr` = `ptr`; `wr_data` = byte.
  - `ptr` ← `ptr` + 1, mod 16 (15 wraps to 0).
- **RD:** drive `sda_oe` = ~`shift[7]` after each SCL fall; shift on each SCL rise. After 8 bits, release SDA → RD_ACK.
- **RD_ACK:** sample the initiator's bit on SCL rise.
  - ACK (0): `ptr` ← `ptr` + 1, reload `shift` from the new `ptr` → RD.
  - NACK (1): → WAIT_P.
- **WAIT_P:** SDA released; wait for STOP or START.
- **Collision:** if an I2C bank write and `usr_we` land in the same cycle at the same index, the I2C write wins and the fabric write is dropped. Writes to different indices both commit.

## Timing
- **Reset values:**
  - `sda_oe` = 0, `busy` = 0, `wr_strobe` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `ptr` = 0; all bank entries = 8'h00; FSM in IDLE.
- **Reset mid-transfer:** SDA is released in the same cycle (asynchronous); the FSM ignores the bus until the next START.
- **Input latency:** sampling occurs 2 cycles after the pin edge (2 + `FILTER_CYC` with the filter enabled).
- **SDA drive point:** `sda_oe` updates 1 cycle after the detected SCL fall, which is within the SCL low phase because `sys_clk` ≥ 20 × SCL.
- **Write latency:** `wr_strobe` asserts 1 cycle after the 8th-bit SCL rise is detected. `bank` and `usr_rdata` reflect the new value in the same cycle.
- **Read snapshot:** read data is captured into `shift` at load time. Fabric writes after the load do not affect the byte in flight.

## Configuration
- `I2C_TGT_GLITCH_FILTER_EN` defined:
  - Each synchronized line feeds a counter filter.
  - The filtered output changes only after the input has held a new level for `FILTER_CYC` consecutive cycles.
  - Pulses shorter than `FILTER_CYC` cycles are suppressed.
- Undefined: the 2-FF synchronizer output is used directly, and no pulse is suppressed.

## Test plan
- **Write burst:** START, 0x74 (addr 0x3A, W), 0x05, 0x11, 0x22, STOP.
  - Expect ACK on all 4 bytes.
  - `bank[5]` = 0x11, `bank[6]` = 0x22.
  - Two `wr_strobe` pulses with (`wr_addr`, `wr_data`) = (5, 0x11) then (6, 0x22).
  - `busy` low after STOP.
- **Pointer write then read:** preload `bank[15]` = 0xA5 and `bank[0]` = 0x3C via `usr_we`. Then START, 0x74, 0x0F, repeated START, 0x75, read 2 bytes (ACK then NACK), STOP.
  - Read data is 0xA5 then 0x3C (wrap from 15 to 0).
  - SDA is released after the NACK.
- **Address mismatch:** START, 0x40, 0x01, 0xFF, STOP.
  - `sda_oe` never asserts; no `wr_strobe`; bank unchanged; `busy` stays 0.
- **Collision:** an I2C write to index 3 and `usr_we` with `usr_addr` = 3 land in the same cycle.
  - `bank[3]` holds the I2C byte.
- **Reset mid-read:** assert `sys_rst_n` = 0 while `sda_oe` = 1 in RD.
  - `sda_oe` = 0 immediately; all outputs at reset values.
  - A following full write transaction completes normally.
- **Glitch:** with `I2C_TGT_GLITCH_FILTER_EN` defined and `FILTER_CYC` = 3, inject 2-cycle SCL high pulses during a write.
  - No extra bits are sampled; data is correct.
  - Without the macro, the same stimulus corrupts the byte.
